// File: rtl/line_buffer_ctrl.sv
// Ring sequencer for NUM_LB line buffers feeding a 3x3 window stage.
// Define LB_CTRL_OVF_EN to add a sticky overflow flag (o_overflow / i_ovf_clr).
module line_buffer_ctrl #(
    parameter int RL         = 640,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LB     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef LB_CTRL_OVF_EN
    input  logic                  i_ovf_clr,
    output logic                  o_overflow,
`endif
    input  logic                  i_pix_valid,
    input  logic [DATA_WIDTH-1:0] i_pix_data,
    output logic                  o_pix_ready,
    output logic [NUM_LB-1:0]     o_lb_wren,
    output logic [DATA_WIDTH-1:0] o_lb_data,
    input  logic                  i_rd_ready,
    output logic [NUM_LB-1:0]     o_lb_rden,
    output logic                  o_win_valid,
    output logic [1:0]            o_win_sel,
    output logic                  o_line_done
);

    localparam int CW = $clog2(RL);
    localparam int TW = $clog2(NUM_LB * RL + 1);
    localparam logic [CW-1:0] RL_LAST = CW'(RL - 1);
    localparam logic [TW-1:0] LINE    = TW'(RL);
    localparam logic [TW-1:0] THREE   = TW'(3 * RL);
    localparam logic [TW-1:0] FULL    = TW'(NUM_LB * RL);

    typedef enum logic [0:0] {IDLE, READ} state_t;

    state_t          state;
    logic [1:0]      wr_sel;
    logic [1:0]      rd_sel;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [TW-1:0]   total_cnt;
    logic            wr_fire;
    logic            rd_fire;
    logic            retire;

    always_comb begin
        o_pix_ready = (total_cnt < FULL);
        wr_fire     = i_pix_valid & o_pix_ready;
        rd_fire     = (state == READ) & i_rd_ready;
        retire      = rd_fire & (rd_cnt == RL_LAST);
        o_lb_data   = i_pix_data;
        o_lb_wren   = wr_fire ? (NUM_LB'(1) << wr_sel) : '0;
        // The three read rows are every buffer except the one three ahead of rd_sel.
        o_lb_rden   = rd_fire ? ~(NUM_LB'(1) << (rd_sel + 2'd3)) : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            wr_sel      <= '0;
            rd_sel      <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            total_cnt   <= '0;
            o_win_valid <= 1'b0;
            o_win_sel   <= '0;
            o_line_done <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_cnt == RL_LAST) begin
                    wr_cnt <= '0;
                    wr_sel <= wr_sel + 2'd1;
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end
            total_cnt   <= total_cnt + TW'(wr_fire) - (retire ? LINE : '0);
            // Window qualifiers trail o_lb_rden by the buffer's read latency.
            o_win_valid <= rd_fire;
            o_win_sel   <= rd_sel;
            o_line_done <= retire;
            case (state)
                IDLE: begin
                    if (total_cnt >= THREE) state <= READ;
                end
                READ: begin
                    if (rd_fire) begin
                        if (rd_cnt == RL_LAST) begin
                            rd_cnt <= '0;
                            rd_sel <= rd_sel + 2'd1;
                            state  <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LB_CTRL_OVF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_overflow <= 1'b0;
        end else if (i_pix_valid & ~o_pix_ready) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed scoreboard bench for line_buffer_ctrl with RL=8.
module tb_line_buffer_ctrl;
    localparam int RL  = 8;
    localparam int DW  = 8;
    localparam int NLB = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_pix_valid = 1'b0;
    logic [DW-1:0] i_pix_data = '0;
    logic          i_rd_ready = 1'b0;
    logic          o_pix_ready;
    logic [NLB-1:0] o_lb_wren;
    logic [DW-1:0] o_lb_data;
    logic [NLB-1:0] o_lb_rden;
    logic          o_win_valid;
    logic [1:0]    o_win_sel;
    logic          o_line_done;
`ifdef LB_CTRL_OVF_EN
    logic          i_ovf_clr = 1'b0;
    logic          o_overflow;
    logic          m_ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_total;
    int         m_wr_cnt;
    int         m_rd_cnt;
    logic [1:0] m_wr_sel;
    logic [1:0] m_rd_sel;
    logic       m_read;
    logic       m_wv;
    logic       m_ld;
    logic       e_wfire;
    logic       e_rfire;
    logic [1:0] sb[$];

    always #5 CLK = ~CLK;

    line_buffer_ctrl #(.RL(RL), .DATA_WIDTH(DW), .NUM_LB(NLB)) dut (
        .CLK         (CLK),
        .RST         (RST),
`ifdef LB_CTRL_OVF_EN
        .i_ovf_clr   (i_ovf_clr),
        .o_overflow  (o_overflow),
`endif
        .i_pix_valid (i_pix_valid),
        .i_pix_data  (i_pix_data),
        .o_pix_ready (o_pix_ready),
        .o_lb_wren   (o_lb_wren),
        .o_lb_data   (o_lb_data),
        .i_rd_ready  (i_rd_ready),
        .o_lb_rden   (o_lb_rden),
        .o_win_valid (o_win_valid),
        .o_win_sel   (o_win_sel),
        .o_line_done (o_line_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_total  = 0;
        m_wr_cnt = 0;
        m_rd_cnt = 0;
        m_wr_sel = 2'd0;
        m_rd_sel = 2'd0;
        m_read   = 1'b0;
        m_wv     = 1'b0;
        m_ld     = 1'b0;
        e_wfire  = 1'b0;
        e_rfire  = 1'b0;
`ifdef LB_CTRL_OVF_EN
        m_ovf    = 1'b0;
`endif
        sb.delete();
    endtask

    // Apply inputs for one cycle and check every output against the model.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        logic [3:0] ew;
        logic [3:0] er;
        i_pix_valid = v;
        i_pix_data  = d;
        i_rd_ready  = r;
        #1;
        e_wfire = v && (m_total < NLB * RL);
        e_rfire = m_read && r;
        ew = 4'b0000;
        er = 4'b0000;
        if (e_wfire) ew[m_wr_sel] = 1'b1;
        if (e_rfire) for (int k = 0; k < 3; k++) er[m_rd_sel + 2'(k)] = 1'b1;
        chk("pix_ready", 32'(o_pix_ready), 32'(m_total < NLB * RL));
        chk("wren", 32'(o_lb_wren), 32'(ew));
        chk("lb_data", 32'(o_lb_data), 32'(d));
        chk("rden", 32'(o_lb_rden), 32'(er));
        chk("win_valid", 32'(o_win_valid), 32'(m_wv));
        chk("line_done", 32'(o_line_done), 32'(m_ld));
`ifdef LB_CTRL_OVF_EN
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
`endif
        if (o_win_valid === 1'b1) begin
            if (sb.size() == 0) chk("sb_size", 32'(sb.size()), 32'd1);
            else chk("win_sel", 32'(o_win_sel), 32'(sb.pop_front()));
        end
        if (e_rfire) sb.push_back(m_rd_sel);
    endtask

    // Advance the model across the clock edge.
    task automatic clk();
        logic retire;
        retire = e_rfire && (m_rd_cnt == RL - 1);
`ifdef LB_CTRL_OVF_EN
        if (i_pix_valid && !(m_total < NLB * RL)) m_ovf = 1'b1;
        else if (i_ovf_clr) m_ovf = 1'b0;
`endif
        if (e_wfire) begin
            if (m_wr_cnt == RL - 1) begin
                m_wr_cnt = 0;
                m_wr_sel = m_wr_sel + 2'd1;
            end else begin
                m_wr_cnt++;
            end
        end
        if (!m_read) begin
            if (m_total >= 3 * RL) m_read = 1'b1;
        end else if (e_rfire) begin
            if (m_rd_cnt == RL - 1) begin
                m_rd_cnt = 0;
                m_rd_sel = m_rd_sel + 2'd1;
                m_read   = 1'b0;
            end else begin
                m_rd_cnt++;
            end
        end
        m_total = m_total + (e_wfire ? 1 : 0) - (retire ? RL : 0);
        m_wv    = e_rfire;
        m_ld    = retire;
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        drive(v, d, r);
        clk();
    endtask

    task automatic do_reset();
        i_pix_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_rden", 32'(o_lb_rden), 32'd0);
        chk("rst_wren", 32'(o_lb_wren), 32'd0);
        chk("rst_win_valid", 32'(o_win_valid), 32'd0);
        chk("rst_win_sel", 32'(o_win_sel), 32'd0);
        chk("rst_line_done", 32'(o_line_done), 32'd0);
        chk("rst_pix_ready", 32'(o_pix_ready), 32'd1);
`ifdef LB_CTRL_OVF_EN
        chk("rst_overflow", 32'(o_overflow), 32'd0);
`endif
        i_rd_ready = 1'b0;
        i_pix_data = '0;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int fires;
        int n;
        model_reset();

        // 1: fill three lines, first read pass starts on buffers 0..2
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, DW'(i + 1), 1'b0);
            chk("t1_wren_walk", 32'(o_lb_wren), 32'(4'b0001 << (i / 8)));
            clk();
        end
        step(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        chk("t1_first_rden", 32'(o_lb_rden), 32'(4'b0111));
        clk();
        drive(1'b0, '0, 1'b1);
        chk("t1_win_valid", 32'(o_win_valid), 32'd1);
        chk("t1_win_sel", 32'(o_win_sel), 32'd0);
        clk();

        // 2: finish the pass with continuous ready
        for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        chk("t2_line_done", 32'(o_line_done), 32'd1);
        clk();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'hA0 + i), 1'b0);
        step(1'b0, '0, 1'b0);

        // 3: alternate ready; second pass reads buffers 1..3
        fires = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, '0, (c % 2) == 0);
            if (c == 0) chk("t2_second_rden", 32'(o_lb_rden), 32'(4'b1110));
            if (c > 0) chk("t3_win_mirror", 32'(o_win_valid), 32'((c - 1) % 2 == 0));
            if (c == 15) chk("t3_line_done", 32'(o_line_done), 32'd1);
            if (o_lb_rden != 4'b0000) fires++;
            clk();
        end
        chk("t3_fire_count", 32'(fires), 32'd8);

        // 4: fill all four buffers with no reads, then drop one pixel
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            chk("t4_ready", 32'(o_pix_ready), 32'd1);
            clk();
        end
        drive(1'b1, 8'hEE, 1'b0);
        chk("t4_ready_low", 32'(o_pix_ready), 32'd0);
        chk("t4_drop_wren", 32'(o_lb_wren), 32'd0);
        clk();
`ifdef LB_CTRL_OVF_EN
        drive(1'b0, '0, 1'b0);
        chk("t4_ovf_set", 32'(o_overflow), 32'd1);
        i_ovf_clr = 1'b1;
        clk();
        i_ovf_clr = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk("t4_ovf_clr", 32'(o_overflow), 32'd0);
        clk();
`endif

        // 5: retire while full with a pixel waiting, then a true write+retire
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, DW'(8'h50 + c), 1'b1);
            if (c == 7) chk("t5_retire_no_wr", 32'(o_lb_wren), 32'd0);
            clk();
        end
        drive(1'b1, 8'h60, 1'b0);
        chk("t5_ready_back", 32'(o_pix_ready), 32'd1);
        chk("t5_wren", 32'(o_lb_wren), 32'(4'b0001));
        clk();
        for (int c = 0; c < 8; c++) begin
            drive(c == 7, 8'h70, 1'b1);
            if (c == 7) begin
                chk("t5_sim_wren", 32'(o_lb_wren), 32'(4'b0001));
                chk("t5_sim_rden", 32'(o_lb_rden), 32'(4'b1110));
            end
            clk();
        end
        n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, DW'(k), 1'b0);
            if (o_lb_wren != 4'b0000) n++;
            clk();
        end
        chk("t5_refill_count", 32'(n), 32'd14);

        // 6: reset in the middle of a read pass, then start over
        do_reset();
        for (int i = 0; i < 24; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        chk("t6_rden_before", 32'(o_lb_rden), 32'(4'b0111));
        do_reset();
        for (int i = 0; i < 24; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        chk("t6_first_rden", 32'(o_lb_rden), 32'(4'b0111));
        clk();
        step(1'b0, '0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
